// File: rtl/csr_sched_pkg.sv
// Shared constants, state encoding and address-map helpers for the
// machine-mode CSR access scheduler.
package csr_sched_pkg;

  // Machine-mode CSR addresses served by the register file
  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MISA       = 12'h301;
  localparam logic [11:0] CSR_MIE        = 12'h304;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [11:0] CSR_MIP        = 12'h344;
  localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID    = 12'hF12;
  localparam logic [11:0] CSR_MIMPID     = 12'hF13;
  localparam logic [11:0] CSR_MHARTID    = 12'hF14;

  // Execute-stage operation encodings
  localparam logic [1:0] OP_RSVD = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // mstatus bit positions touched by trap entry
  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    I_RD    = 4'd1,
    I_WR    = 4'd2,
    I_DONE  = 4'd3,
    T_EPC   = 4'd4,
    T_CAUSE = 4'd5,
    T_STR   = 4'd6,
    T_STW   = 4'd7,
    T_VECR  = 4'd8,
    T_DONE  = 4'd9
  } sched_state_e;

  // True when the address is one of the implemented machine CSRs
  function automatic logic csr_addr_known(input logic [11:0] addr);
    logic known;
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MCOUNTEREN,
      CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET,
      CSR_MCYCLEH, CSR_MINSTRETH, CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID: known = 1'b1;
      default:                 known = 1'b0;
    endcase
    return known;
  endfunction

  // True for the read-only machine information registers
  function automatic logic csr_addr_ro(input logic [11:0] addr);
    logic ro;
    case (addr)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: ro = 1'b1;
      default:                                             ro = 1'b0;
    endcase
    return ro;
  endfunction

endpackage

// File: rtl/csr_access_sched_trap_calc.sv
// Trap-entry arithmetic: the updated mstatus image and the handler PC.
module csr_trap_calc
  import csr_sched_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic [XLEN-1:0] mstatus_old_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] cause_i,
  output logic [XLEN-1:0] mstatus_new_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic [XLEN-1:0] base_s;
  logic            unused_s;

  // Bit 30 of the cause shifts out of the vector offset and is never needed
  assign unused_s = cause_i[XLEN-2];

  // Stack MIE into MPIE, disable interrupts, record machine mode as previous
  always_comb begin
    mstatus_new_o                        = mstatus_old_i;
    mstatus_new_o[MST_MPIE]              = mstatus_old_i[MST_MIE];
    mstatus_new_o[MST_MIE]               = 1'b0;
    mstatus_new_o[MST_MPP_HI:MST_MPP_LO] = 2'b11;
  end

  // Direct or vectored handler address; modes 10/11 fall back to direct
  always_comb begin
    base_s = {mtvec_i[XLEN-1:2], 2'b00};
    if (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && cause_i[XLEN-1]) begin
      redirect_pc_o = base_s + {cause_i[XLEN-3:0], 2'b00};
    end else begin
      redirect_pc_o = base_s;
    end
  end

endmodule

// File: rtl/csr_access_sched.sv
// Single-port CSR file sequencer: read-modify-write for the execute stage
// and the fixed trap-entry sequence for the trap unit, trap having priority.
module csr_access_sched
  import csr_sched_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_req_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            csr_src_zero_i,
  output logic            csr_ack_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  output logic            trap_ack_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     rf_addr_o,
  output logic            rf_we_o,
  output logic            rf_re_o,
  output logic [XLEN-1:0] rf_wdata_o,
  input  logic [XLEN-1:0] rf_rdata_i
);

  sched_state_e    state_r, state_s;
  logic            we_r, we_s, re_r, re_s;
  logic [11:0]     rf_addr_r, rf_addr_s;
  logic            ack_r, ack_s, illegal_r, illegal_s, tack_r, tack_s;
  logic            accept_trap_s, accept_csr_s;
  logic            wr_intent_s, csr_legal_s;
  logic [1:0]      op_r;
  logic [11:0]     addr_r;
  logic [XLEN-1:0] wdata_r, cause_r, rdata_r, redirect_r;
  logic [XLEN-1:2] pc_r;
  logic            wr_intent_r;
  logic [XLEN-1:0] rmw_s, mstatus_new_s, redirect_s, rf_wdata_s;
  logic            unused_s;

  // mepc is word aligned, so the two low PC bits are dropped at capture
  assign unused_s = ^trap_pc_i[1:0];

  // Write intent and legality of the execute-stage request as presented
  assign wr_intent_s = (csr_op_i == OP_RW) ||
                       (((csr_op_i == OP_RS) || (csr_op_i == OP_RC)) && !csr_src_zero_i);
  assign csr_legal_s = csr_addr_known(csr_addr_i) && (csr_op_i != OP_RSVD) &&
                       !(wr_intent_s && csr_addr_ro(csr_addr_i));

  csr_trap_calc #(
    .XLEN        (XLEN),
    .VECTORED_EN (VECTORED_EN)
  ) u_trap_calc (
    .mstatus_old_i (rf_rdata_i),
    .mtvec_i       (rf_rdata_i),
    .cause_i       (cause_r),
    .mstatus_new_o (mstatus_new_s),
    .redirect_pc_o (redirect_s)
  );

  // Next state plus next-cycle file strobes, address and handshake pulses
  always_comb begin
    state_s       = state_r;
    we_s          = 1'b0;
    re_s          = 1'b0;
    rf_addr_s     = 12'h000;
    ack_s         = 1'b0;
    illegal_s     = 1'b0;
    tack_s        = 1'b0;
    accept_trap_s = 1'b0;
    accept_csr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (trap_req_i) begin
          accept_trap_s = 1'b1;
          state_s       = T_EPC;
          we_s          = 1'b1;
          rf_addr_s     = CSR_MEPC;
        end else if (csr_req_i) begin
          accept_csr_s = 1'b1;
          if (csr_legal_s) begin
            state_s   = I_RD;
            re_s      = 1'b1;
            rf_addr_s = csr_addr_i;
          end else begin
            state_s   = I_DONE;
            ack_s     = 1'b1;
            illegal_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      I_RD: begin
        state_s   = I_WR;
        we_s      = wr_intent_r;
        rf_addr_s = addr_r;
      end
      I_WR: begin
        state_s = I_DONE;
        ack_s   = 1'b1;
      end
      T_EPC: begin
        state_s   = T_CAUSE;
        we_s      = 1'b1;
        rf_addr_s = CSR_MCAUSE;
      end
      T_CAUSE: begin
        state_s   = T_STR;
        re_s      = 1'b1;
        rf_addr_s = CSR_MSTATUS;
      end
      T_STR: begin
        state_s   = T_STW;
        we_s      = 1'b1;
        rf_addr_s = CSR_MSTATUS;
      end
      T_STW: begin
        state_s   = T_VECR;
        re_s      = 1'b1;
        rf_addr_s = CSR_MTVEC;
      end
      T_VECR: begin
        state_s = T_DONE;
        tack_s  = 1'b1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Read-modify-write result from the value the file returned this cycle
  always_comb begin
    case (op_r)
      OP_RW:   rmw_s = wdata_r;
      OP_RS:   rmw_s = rf_rdata_i | wdata_r;
      OP_RC:   rmw_s = rf_rdata_i & ~wdata_r;
      default: rmw_s = wdata_r;
    endcase
  end

  // Write data depends on same-cycle read data, so it is decoded from state
  always_comb begin
    case (state_r)
      I_WR:    rf_wdata_s = rmw_s;
      T_EPC:   rf_wdata_s = {pc_r, 2'b00};
      T_CAUSE: rf_wdata_s = cause_r;
      T_STW:   rf_wdata_s = mstatus_new_s;
      default: rf_wdata_s = {XLEN{1'b0}};
    endcase
  end

  // State, registered strobes, captured request fields and latched results
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      re_r        <= 1'b0;
      rf_addr_r   <= 12'h000;
      ack_r       <= 1'b0;
      illegal_r   <= 1'b0;
      tack_r      <= 1'b0;
      op_r        <= OP_RSVD;
      addr_r      <= 12'h000;
      wdata_r     <= {XLEN{1'b0}};
      wr_intent_r <= 1'b0;
      pc_r        <= {(XLEN-2){1'b0}};
      cause_r     <= {XLEN{1'b0}};
      rdata_r     <= {XLEN{1'b0}};
      redirect_r  <= {XLEN{1'b0}};
    end else begin
      state_r   <= state_s;
      we_r      <= we_s;
      re_r      <= re_s;
      rf_addr_r <= rf_addr_s;
      ack_r     <= ack_s;
      illegal_r <= illegal_s;
      tack_r    <= tack_s;
      if (accept_trap_s) begin
        pc_r    <= trap_pc_i[XLEN-1:2];
        cause_r <= trap_cause_i;
      end
      if (accept_csr_s) begin
        op_r        <= csr_op_i;
        addr_r      <= csr_addr_i;
        wdata_r     <= csr_wdata_i;
        wr_intent_r <= wr_intent_s;
        rdata_r     <= {XLEN{1'b0}};
      end else if (state_r == I_WR) begin
        rdata_r <= rf_rdata_i;
      end
      if (state_r == T_DONE) begin
        redirect_r <= redirect_s;
      end
    end
  end

  assign csr_ack_o     = ack_r;
  assign csr_illegal_o = illegal_r;
  assign csr_rdata_o   = rdata_r;
  assign trap_ack_o    = tack_r;
  assign redirect_pc_o = (state_r == T_DONE) ? redirect_s : redirect_r;
  assign rf_addr_o     = {20'h00000, rf_addr_r};
  assign rf_we_o       = we_r;
  assign rf_re_o       = re_r;
  assign rf_wdata_o    = rf_wdata_s;

endmodule
